// File: rtl/onchip_mem_test_pkg.sv
// Shared types and constants for the on-chip memory test master.
// The FSM state set, the mode encoding and the error-counter ceiling live here.
package onchip_mem_test_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        READ,
        DRAIN,
        FIN
    } state_t;

    localparam logic MODE_FILL   = 1'b0;
    localparam logic MODE_VERIFY = 1'b1;

    localparam logic [15:0] ERR_SAT = 16'hFFFF;

endpackage

// File: rtl/mem_addr_pattern_gen.sv
// Wrapping word-address counter and seed+i data counter.
// Load takes priority over step. The address wraps at DEPTH with a compare, so no divider is needed.
module mem_addr_pattern_gen #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 37500
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [DATA_W-1:0] seed,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr <= '0;
            data <= '0;
        end else if (load) begin
            addr <= base_addr;
            data <= seed;
        end else if (step) begin
            addr <= (addr == ADDR_W'(DEPTH - 1)) ? '0 : addr + ADDR_W'(1);
            data <= data + DATA_W'(1);
        end
    end

endmodule

// File: rtl/onchip_mem_test_master.sv
// Avalon-MM master that fills a word range with seed+i and verifies it on read-back.
// It issues one access per cycle and compares read data RD_LAT cycles after each read.
module onchip_mem_test_master
    import onchip_mem_test_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 37500,
    parameter int RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  mode,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [15:0]           word_count,
    input  logic [DATA_W-1:0]     seed,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           err_count,
    output logic [ADDR_W-1:0]     first_err_addr,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata
);

    state_t              state, next_state;
    logic [15:0]         remaining;
    logic [7:0]          drain_cnt;
    logic                accept, last_word, access, gen_load, gen_step, rd_issue;
    logic [ADDR_W-1:0]   gen_addr;
    logic [DATA_W-1:0]   gen_data;

    logic [RD_LAT-1:0]   pipe_vld;
    logic [DATA_W-1:0]   pipe_exp  [RD_LAT];
    logic [ADDR_W-1:0]   pipe_addr [RD_LAT];

    assign accept    = (state == IDLE) && start;
    assign last_word = (remaining == 16'd1);
    assign access    = (state == FILL) || (state == READ);
    assign rd_issue  = (state == READ);
    assign gen_load  = accept && (word_count != 16'd0);
    // The counter is not advanced past the last word, so address/data hold the final access.
    assign gen_step  = access && !last_word;

    mem_addr_pattern_gen #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_gen (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (gen_load),
        .step      (gen_step),
        .base_addr (base_addr),
        .seed      (seed),
        .addr      (gen_addr),
        .data      (gen_data)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            remaining <= '0;
            drain_cnt <= '0;
        end else begin
            state <= next_state;
            if (accept)
                remaining <= word_count;
            else if (gen_step)
                remaining <= remaining - 16'd1;
            drain_cnt <= (state == DRAIN) ? drain_cnt + 8'd1 : 8'd0;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        next_state     = state;
        busy           = 1'b0;
        done           = 1'b0;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (word_count == 16'd0)
                        next_state = FIN;
                    else if (mode == MODE_FILL)
                        next_state = FILL;
                    else
                        next_state = READ;
                end
            end
            FILL: begin
                busy           = 1'b1;
                mem_chipselect = 1'b1;
                mem_write      = 1'b1;
                if (last_word) next_state = FIN;
            end
            READ: begin
                busy           = 1'b1;
                mem_chipselect = 1'b1;
                if (last_word) next_state = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_cnt == 8'(RD_LAT - 1)) next_state = FIN;
            end
            FIN: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_vld <= '0;
        end else begin
            pipe_vld[0] <= rd_issue;
            for (int j = 1; j < RD_LAT; j++)
                pipe_vld[j] <= pipe_vld[j-1];
        end
    end

    // NOTE: the expected-data stages carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
        pipe_exp[0]  <= gen_data;
        pipe_addr[0] <= gen_addr;
        for (int j = 1; j < RD_LAT; j++) begin
            pipe_exp[j]  <= pipe_exp[j-1];
            pipe_addr[j] <= pipe_addr[j-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_count      <= '0;
            first_err_addr <= '0;
        end else if (gen_load && (mode == MODE_VERIFY)) begin
            err_count      <= '0;
            first_err_addr <= '0;
        end else if (pipe_vld[RD_LAT-1] && (mem_readdata != pipe_exp[RD_LAT-1])) begin
            if (err_count == 16'd0)
                first_err_addr <= pipe_addr[RD_LAT-1];
            if (err_count != ERR_SAT)
                err_count <= err_count + 16'd1;
        end
    end

    assign mem_address    = gen_addr;
    assign mem_writedata  = gen_data;
    assign mem_byteenable = {(DATA_W/8){mem_chipselect}};
    assign mem_clken      = 1'b1;

endmodule

// File: tb/tb_onchip_mem_test_master.sv
// Randomised self-checking bench for onchip_mem_test_master.
// It uses a RAM slave with one-cycle read latency and a word-level reference model of the run.
module tb_onchip_mem_test_master;
    import onchip_mem_test_pkg::*;

    localparam int DEPTH = 37500;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [15:0] base_addr = '0;
    logic [15:0] word_count = '0;
    logic [31:0] seed = '0;
    logic        busy, done, mem_chipselect, mem_write, mem_clken;
    logic [15:0] err_count, first_err_addr, mem_address;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata = '0;

    logic [31:0] ram     [0:DEPTH-1];
    logic [31:0] ref_mem [0:DEPTH-1];
    logic        bd_en = 1'b0;
    logic [15:0] bd_addr = '0;
    logic [31:0] bd_data = '0;

    int vectors = 0;
    int miscompares = 0;
    int err_model = 0;
    int ferr_model = 0;

    always #5 clk = ~clk;

    onchip_mem_test_master dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .mode           (mode),
        .base_addr      (base_addr),
        .word_count     (word_count),
        .seed           (seed),
        .busy           (busy),
        .done           (done),
        .err_count      (err_count),
        .first_err_addr (first_err_addr),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata)
    );

    // Slave RAM with a single-cycle registered read; backdoor port for fault injection.
    always @(posedge clk) begin
        if (bd_en)
            ram[bd_addr] <= bd_data;
        else if (mem_chipselect) begin
            if (mem_write)
                ram[mem_address] <= mem_writedata;
            else
                mem_readdata <= ram[mem_address];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int wrap_addr(input int base, input int i);
        return (base + i) % DEPTH;
    endfunction

    task automatic backdoor(input int a, input logic [31:0] v);
        @(negedge clk);
        bd_en   = 1'b1;
        bd_addr = 16'(a);
        bd_data = v;
        @(negedge clk);
        bd_en      = 1'b0;
        ref_mem[a] = v;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_err"}, err_count, 16'd0);
        check({tag, "_ferr"}, first_err_addr, 16'd0);
        check({tag, "_addr"}, mem_address, 16'd0);
        check({tag, "_be"}, mem_byteenable, 4'h0);
        check({tag, "_cs"}, mem_chipselect, 1'b0);
        check({tag, "_wr"}, mem_write, 1'b0);
        check({tag, "_wdata"}, mem_writedata, 32'd0);
        check({tag, "_clken"}, mem_clken, 1'b1);
    endtask

    // One complete run: the model predicts every cycle from start to one cycle past done.
    task automatic run_op(input logic m, input int base, input int n, input logic [31:0] s,
                          input bit inject);
        int done_cyc;
        int exp_err;
        int exp_ferr;
        logic acc;
        done_cyc = (n == 0) ? 1 : ((m == MODE_FILL) ? n + 1 : n + 2);
        exp_err  = err_model;
        exp_ferr = ferr_model;
        if (n > 0 && m == MODE_VERIFY) begin
            exp_err  = 0;
            exp_ferr = 0;
            for (int i = 0; i < n; i++) begin
                if (ref_mem[wrap_addr(base, i)] !== s + 32'(i)) begin
                    if (exp_err == 0) exp_ferr = wrap_addr(base, i);
                    if (exp_err < 65535) exp_err++;
                end
            end
        end
        @(negedge clk);
        start      = 1'b1;
        mode       = m;
        base_addr  = 16'(base);
        word_count = 16'(n);
        seed       = s;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= done_cyc + 1; c++) begin
            acc = (c <= n);
            check("cs", mem_chipselect, acc);
            check("wr", mem_write, acc && (m == MODE_FILL));
            check("be", mem_byteenable, acc ? 4'hF : 4'h0);
            check("busy", busy, c < done_cyc);
            check("done", done, c == done_cyc);
            if (acc) begin
                check("addr", mem_address, 32'(wrap_addr(base, c - 1)));
                if (m == MODE_FILL) check("wdata", mem_writedata, s + 32'(c - 1));
            end
            if (c >= done_cyc && n > 0) begin
                check("addr_hold", mem_address, 32'(wrap_addr(base, n - 1)));
                if (m == MODE_FILL) check("wdata_hold", mem_writedata, s + 32'(n - 1));
            end
            if (c >= done_cyc) begin
                check("err_count", err_count, 32'(exp_err));
                check("first_err", first_err_addr, 32'(exp_ferr));
            end
            if (inject && c == 2) begin
                start      = 1'b1;
                mode       = MODE_VERIFY;
                base_addr  = 16'd0;
                word_count = 16'd3;
                seed       = 32'h0;
            end
            if (inject && c == 3) start = 1'b0;
            @(negedge clk);
        end
        err_model  = exp_err;
        ferr_model = exp_ferr;
        if (m == MODE_FILL)
            for (int i = 0; i < n; i++) ref_mem[wrap_addr(base, i)] = s + 32'(i);
    endtask

    initial begin
        int base, n, k;
        logic [31:0] s, vs;

        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset_n = 1'b1;
        @(negedge clk);

        run_op(MODE_FILL, 16'h0010, 4, 32'hA5A5_0000, 1'b1);
        run_op(MODE_VERIFY, 16'h0010, 4, 32'hA5A5_0000, 1'b0);
        check("clean_err", err_count, 16'd0);

        backdoor(16'h0012, 32'd0);
        backdoor(16'h0013, 32'd1);
        run_op(MODE_VERIFY, 16'h0010, 4, 32'hA5A5_0000, 1'b0);
        check("fault_err", err_count, 16'd2);
        check("fault_ferr", first_err_addr, 16'h0012);

        run_op(MODE_FILL, 37498, 4, 32'h1234_5678, 1'b0);
        run_op(MODE_VERIFY, 37498, 4, 32'h1234_5678, 1'b0);
        run_op(MODE_FILL, 16'h0100, 0, 32'hDEAD_BEEF, 1'b0);

        for (int it = 0; it < 12; it++) begin
            base = ($urandom_range(0, 3) == 0) ? DEPTH - 1 - int'($urandom_range(0, 6))
                                               : int'($urandom_range(0, DEPTH - 1));
            n = int'($urandom_range(1, 24));
            s = $urandom;
            run_op(MODE_FILL, base, n, s, 1'b0);
            k = int'($urandom_range(0, 3));
            for (int j = 0; j < k; j++)
                backdoor(wrap_addr(base, int'($urandom_range(0, n - 1))), $urandom);
            vs = ($urandom_range(0, 3) == 0) ? s + 32'd1 : s;
            run_op(MODE_VERIFY, base, n, vs, 1'b0);
        end

        // Abort a VERIFY run with reset after its third read.
        run_op(MODE_FILL, 16'h0010, 4, 32'hA5A5_0000, 1'b0);
        @(negedge clk);
        start      = 1'b1;
        mode       = MODE_VERIFY;
        base_addr  = 16'h0010;
        word_count = 16'd4;
        seed       = 32'hA5A5_0000;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_abort_cs", mem_chipselect, 1'b1);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        err_model  = 0;
        ferr_model = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("post_abort_done", done, 1'b0);
            check("post_abort_cs", mem_chipselect, 1'b0);
        end

        run_op(MODE_VERIFY, 16'h0010, 4, 32'hA5A5_0000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
